// File: rtl/cfs_rr_fifo.sv
// Multi-channel FIFO bank merged onto one output through a round-robin arbiter.
// Optional per-channel rejected-push counter: define CFS_RR_FIFO_DROP_CNT_EN.
module cfs_rr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CH     = 4,
    parameter int AFULL_LVL  = 6,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH),
    localparam int CH_WIDTH  = $clog2(NUM_CH),
    localparam int LVL_W     = CNT_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            push_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] push_data,
    output logic [NUM_CH-1:0]            push_ready,
    input  logic [NUM_CH-1:0]            clear,
    output logic                         pop_valid,
    output logic [DATA_WIDTH-1:0]        pop_data,
    output logic [CH_WIDTH-1:0]          pop_ch,
    input  logic                         pop_ready,
    output logic [NUM_CH*LVL_W-1:0]      fifo_lvl,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH-1:0]            afull
`ifdef CFS_RR_FIFO_DROP_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]          drop_cnt
`endif
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH][FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]  r_wr_ptr [NUM_CH];
    logic [CNT_WIDTH-1:0]  r_rd_ptr [NUM_CH];
    logic [LVL_W-1:0]      r_lvl [NUM_CH];
    logic [CH_WIDTH-1:0]   r_last_grant;
    logic                  r_locked;
    logic [CH_WIDTH-1:0]   r_lock_ch;

    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_elig;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop_vec;
    logic                  w_pop_valid;
    logic                  w_pop;
    logic                  w_rr_found;
    logic [CH_WIDTH-1:0]   w_rr_grant;
    logic [CH_WIDTH-1:0]   w_grant;
    int                    w_idx;

    function automatic logic [CNT_WIDTH-1:0] f_inc(input logic [CNT_WIDTH-1:0] p);
        return (p == CNT_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign w_full[g]  = (r_lvl[g] == LVL_W'(FIFO_DEPTH));
        assign w_empty[g] = (r_lvl[g] == '0);
        assign afull[g]   = (r_lvl[g] >= LVL_W'(AFULL_LVL));
        assign fifo_lvl[g*LVL_W +: LVL_W] = r_lvl[g];
    end

    assign full       = w_full;
    assign empty      = w_empty;
    assign push_ready = ~w_full & ~clear;
    assign w_push     = push_valid & push_ready;
    assign w_elig     = ~w_empty & ~clear;

    // Scan starts one past the last served channel, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        w_idx      = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_CH;
            if (!w_rr_found && w_elig[CH_WIDTH'(w_idx)]) begin
                w_rr_found = 1'b1;
                w_rr_grant = CH_WIDTH'(w_idx);
            end
        end
    end

    // A stalled grant is held unless its channel is being flushed.
    assign w_grant     = (r_locked && !clear[r_lock_ch]) ? r_lock_ch : w_rr_grant;
    assign w_pop_valid = |w_elig;
    assign w_pop       = w_pop_valid & pop_ready;
    assign w_pop_vec   = w_pop ? (NUM_CH'(1) << w_grant) : '0;

    assign pop_valid = w_pop_valid;
    assign pop_ch    = w_pop_valid ? w_grant : '0;
    assign pop_data  = w_pop_valid ? r_mem[w_grant][r_rd_ptr[w_grant]] : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_lvl[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear[i]) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                    r_lvl[i]    <= '0;
                end else begin
                    if (w_push[i]) begin
                        r_wr_ptr[i] <= f_inc(r_wr_ptr[i]);
                    end
                    if (w_pop_vec[i]) begin
                        r_rd_ptr[i] <= f_inc(r_rd_ptr[i]);
                    end
                    if (w_push[i] && !w_pop_vec[i]) begin
                        r_lvl[i] <= r_lvl[i] + 1'b1;
                    end else if (!w_push[i] && w_pop_vec[i]) begin
                        r_lvl[i] <= r_lvl[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= CH_WIDTH'(NUM_CH - 1);
            r_locked     <= 1'b0;
            r_lock_ch    <= '0;
        end else if (w_pop) begin
            r_last_grant <= w_grant;
            r_locked     <= 1'b0;
        end else if (w_pop_valid) begin
            r_locked     <= 1'b1;
            r_lock_ch    <= w_grant;
        end else begin
            r_locked     <= 1'b0;
        end
    end

`ifdef CFS_RR_FIFO_DROP_CNT_EN
    logic [7:0] r_drop [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_drop[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear[i]) begin
                    r_drop[i] <= '0;
                end else if (push_valid[i] && w_full[i] && r_drop[i] != 8'hFF) begin
                    r_drop[i] <= r_drop[i] + 8'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_drop
        assign drop_cnt[g*8 +: 8] = r_drop[g];
    end
`else
    // Rejected pushes on a full channel are discarded without record.
`endif

endmodule

// File: tb/tb_cfs_rr_fifo.sv
// Scoreboard bench for cfs_rr_fifo: directed pushes queue expected pops,
// a negedge monitor pops and compares whenever a transfer happens.
module tb_cfs_rr_fifo;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int LW  = 4;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  push_valid = '0;
    logic [NCH*DW-1:0] push_data = '0;
    logic [NCH-1:0]  push_ready;
    logic [NCH-1:0]  clear = '0;
    logic            pop_valid;
    logic [DW-1:0]   pop_data;
    logic [1:0]      pop_ch;
    logic            pop_ready = 1'b0;
    logic [NCH*LW-1:0] fifo_lvl;
    logic [NCH-1:0]  full;
    logic [NCH-1:0]  empty;
    logic [NCH-1:0]  afull;
`ifdef CFS_RR_FIFO_DROP_CNT_EN
    logic [NCH*8-1:0] drop_cnt;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t m_e;

    cfs_rr_fifo #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(8), .NUM_CH(NCH), .AFULL_LVL(6)
    ) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .clear(clear),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ch(pop_ch),
        .pop_ready(pop_ready),
        .fifo_lvl(fifo_lvl), .full(full), .empty(empty), .afull(afull)
`ifdef CFS_RR_FIFO_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl(input int ch);
        return fifo_lvl[ch*LW +: LW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pop_ready  = 1'b0;
        push_valid = '0;
        clear      = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_data(input int ch, input logic [31:0] d);
        push_data[ch*DW +: DW] = d;
    endtask

    always @(negedge clk) begin
        if (!reset && pop_valid && pop_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got ch%0d data %0h expected none", pop_ch, pop_data);
            end else begin
                m_e = q.pop_front();
                chk("pop_ch", 64'(pop_ch), 64'(m_e.ch));
                chk("pop_data", 64'(pop_data), 64'(m_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'hF);
        chk("rst_push_ready", 64'(push_ready), 64'hF);
        chk("rst_pop_valid", 64'(pop_valid), 64'h0);
        chk("rst_pop_ch", 64'(pop_ch), 64'h0);
        chk("rst_pop_data", 64'(pop_data), 64'h0);
        chk("rst_lvl", 64'(fifo_lvl), 64'h0);
        chk("rst_full_afull", 64'({full, afull}), 64'h0);

        // Fill ch1 to full while the consumer stalls.
        step();
        for (int k = 0; k < 8; k++) begin
            push_valid = 4'b0010;
            set_data(1, 32'h10 + k);
            q.push_back('{2'd1, 32'h10 + k});
            step();
            chk("fill_lvl1", 64'(lvl(1)), 64'(k + 1));
            chk("fill_afull1", 64'(afull[1]), 64'(k + 1 >= 6));
            chk("fill_full1", 64'(full[1]), 64'(k == 7));
            chk("fill_ready1", 64'(push_ready[1]), 64'(k != 7));
        end
        set_data(1, 32'h99);
        chk("ovf_ready1", 64'(push_ready[1]), 64'h0);
        step();
        chk("ovf_lvl1", 64'(lvl(1)), 64'h8);
`ifdef CFS_RR_FIFO_DROP_CNT_EN
        chk("ovf_drop1", 64'(drop_cnt[15:8]), 64'h1);
`endif
        push_valid = '0;
        pop_ready  = 1'b1;
        repeat (8) step();
        pop_ready = 1'b0;
        chk("drain_empty1", 64'(empty[1]), 64'h1);
        chk("drain_sb", 64'(q.size()), 64'h0);

        // Round robin from reset priority.
        do_reset();
        push_valid = 4'b1101;
        set_data(0, 32'hA0); set_data(2, 32'hC0); set_data(3, 32'hD0);
        step();
        push_valid = 4'b1001;
        set_data(0, 32'hA1); set_data(3, 32'hD1);
        step();
        push_valid = '0;
        q.push_back('{2'd0, 32'hA0});
        q.push_back('{2'd2, 32'hC0});
        q.push_back('{2'd3, 32'hD0});
        q.push_back('{2'd0, 32'hA1});
        q.push_back('{2'd3, 32'hD1});
        pop_ready = 1'b1;
        repeat (5) step();
        pop_ready = 1'b0;
        chk("rr_done_valid", 64'(pop_valid), 64'h0);
        chk("rr_sb", 64'(q.size()), 64'h0);

        // Grant held stable while the consumer stalls.
        push_valid = 4'b0011;
        set_data(0, 32'hB0); set_data(1, 32'hB1);
        step();
        push_valid = '0;
        repeat (5) begin
            chk("lock_ch", 64'(pop_ch), 64'h0);
            chk("lock_data", 64'(pop_data), 64'hB0);
            step();
        end
        q.push_back('{2'd0, 32'hB0});
        q.push_back('{2'd1, 32'hB1});
        pop_ready = 1'b1;
        repeat (2) step();
        pop_ready = 1'b0;
        chk("lock_sb", 64'(q.size()), 64'h0);

        // Flushing the locked channel moves the grant.
        push_valid = 4'b1100;
        set_data(2, 32'hE2); set_data(3, 32'hE3);
        step();
        push_valid = '0;
        chk("unlock_pre_ch", 64'(pop_ch), 64'h2);
        step();
        clear = 4'b0100;
        #1;
        chk("unlock_ch", 64'(pop_ch), 64'h3);
        chk("unlock_data", 64'(pop_data), 64'hE3);
        step();
        clear = '0;
        q.push_back('{2'd3, 32'hE3});
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        chk("unlock_empty", 64'(empty), 64'hF);

        // Clear with a same-cycle push on ch2.
        for (int k = 0; k < 3; k++) begin
            push_valid = 4'b0100;
            set_data(2, 32'h20 + k);
            step();
        end
        chk("clr_pre_lvl2", 64'(lvl(2)), 64'h3);
        clear = 4'b0100;
        set_data(2, 32'hDEAD);
        #1;
        chk("clr_ready2", 64'(push_ready[2]), 64'h0);
        step();
        clear = '0;
        push_valid = '0;
        chk("clr_lvl2", 64'(lvl(2)), 64'h0);
        chk("clr_empty2", 64'(empty[2]), 64'h1);
        chk("clr_pop_valid", 64'(pop_valid), 64'h0);

        // Simultaneous push and pop keeps the level.
        for (int k = 0; k < 4; k++) begin
            push_valid = 4'b0001;
            set_data(0, 32'h30 + k);
            step();
        end
        chk("pp_pre_lvl0", 64'(lvl(0)), 64'h4);
        set_data(0, 32'h34);
        q.push_back('{2'd0, 32'h30});
        pop_ready = 1'b1;
        step();
        push_valid = '0;
        pop_ready  = 1'b0;
        chk("pp_lvl0", 64'(lvl(0)), 64'h4);
        chk("pp_head0", 64'(pop_data), 64'h31);

        // Reset mid-stream.
        reset = 1'b1;
        #1;
        chk("mrst_empty", 64'(empty), 64'hF);
        chk("mrst_lvl", 64'(fifo_lvl), 64'h0);
        chk("mrst_pop", 64'({pop_valid, pop_ch, pop_data}), 64'h0);
        chk("mrst_push_ready", 64'(push_ready), 64'hF);
        chk("mrst_full_afull", 64'({full, afull}), 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("end_sb", 64'(q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
